// File: rtl/processor_bc_lanes.sv
// Multi-lane GF(2^GF_BIT) successor PE for the UOV systolic array: per-lane MAC,
// B-column shifting and Gauss elimination, with DEPTH interleaved accumulator banks.
module processor_bc_lanes #(
    parameter int GF_BIT      = 4,
    parameter int LANES       = 2,
    parameter int DEPTH       = 4,
    parameter int OP_CODE_LEN = 4,
    localparam int W          = LANES * GF_BIT,
    localparam int PW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid_in,
    output logic                   valid_out,
    input  logic                   start_in,
    output logic                   start_out,
    input  logic [OP_CODE_LEN-1:0] op_in,
    output logic [OP_CODE_LEN-1:0] op_out,
    input  logic [1:0]             gauss_op_in,
    output logic [1:0]             gauss_op_out,
    input  logic [W-1:0]           key_data,
    input  logic [W-1:0]           data_in,
    output logic [W-1:0]           data_out,
    input  logic [W-1:0]           dataA_in,
    output logic [W-1:0]           dataA_out,
    input  logic [W-1:0]           dataB_in,
    output logic [W-1:0]           dataB_out,
    output logic [W-1:0]           r_out,
    output logic [PW-1:0]          ptr_out
);

    localparam int PRODW    = 2 * GF_BIT - 1;
    localparam int POLY_INT = (GF_BIT == 8) ? 'h11B : 'h13;
    localparam logic [PRODW-1:0] POLY = PRODW'(POLY_INT);

    localparam logic [OP_CODE_LEN-1:0] OP_GAUSS    = OP_CODE_LEN'(1);
    localparam logic [OP_CODE_LEN-1:0] OP_BANK_RST = OP_CODE_LEN'(2);
    localparam logic [OP_CODE_LEN-1:0] OP_LOAD_KEY = OP_CODE_LEN'(3);
    localparam logic [OP_CODE_LEN-1:0] OP_SHIFT0   = OP_CODE_LEN'(4);
    localparam logic [OP_CODE_LEN-1:0] OP_SHIFT1   = OP_CODE_LEN'(5);
    localparam logic [OP_CODE_LEN-1:0] OP_MAC_A    = OP_CODE_LEN'(6);
    localparam logic [OP_CODE_LEN-1:0] OP_MAC_KEY  = OP_CODE_LEN'(7);

    // Carry-less product followed by long division by the field polynomial.
    function automatic logic [GF_BIT-1:0] gf_mul(input logic [GF_BIT-1:0] a,
                                                 input logic [GF_BIT-1:0] b);
        logic [PRODW-1:0] p;
        p = '0;
        for (int i = 0; i < GF_BIT; i++)
            if (b[i]) p = p ^ (PRODW'(a) << i);
        for (int i = PRODW - 1; i >= GF_BIT; i--)
            if (p[i]) p = p ^ (POLY << (i - GF_BIT));
        return p[GF_BIT-1:0];
    endfunction

    logic [GF_BIT-1:0] bank [LANES][DEPTH];
    logic [PW-1:0]     ptr;

    logic [GF_BIT-1:0] cur    [LANES];
    logic [GF_BIT-1:0] mul_a  [LANES];
    logic [GF_BIT-1:0] mul_b  [LANES];
    logic [GF_BIT-1:0] add_b  [LANES];
    logic [GF_BIT-1:0] add_o  [LANES];
    logic [GF_BIT-1:0] wr_val [LANES];
    logic [GF_BIT-1:0] dout_n [LANES];
    logic [GF_BIT-1:0] dbo_n  [LANES];
    logic              is_mac, is_shift, wr_en, ptr_adv;
    logic [PW-1:0]     ptr_next;

    always_comb begin
        is_mac   = (op_in == OP_MAC_A) || (op_in == OP_MAC_KEY);
        is_shift = (op_in == OP_SHIFT0) || (op_in == OP_SHIFT1);
        wr_en    = is_mac || is_shift || (op_in == OP_LOAD_KEY) ||
                   ((op_in == OP_GAUSS) && (start_in || gauss_op_in == 2'b01));
        ptr_adv  = is_mac || is_shift || (op_in == OP_LOAD_KEY);
        ptr_next = (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);

        for (int l = 0; l < LANES; l++) begin
            cur[l]   = bank[l][ptr];
            mul_a[l] = (op_in == OP_MAC_KEY) ? key_data[l*GF_BIT +: GF_BIT]
                                             : dataB_in[l*GF_BIT +: GF_BIT];
            mul_b[l] = is_mac         ? dataA_in[l*GF_BIT +: GF_BIT] :
                       gauss_op_in[0] ? data_in[l*GF_BIT +: GF_BIT]  : cur[l];
            add_b[l] = gauss_op_in[1] ? data_in[l*GF_BIT +: GF_BIT] : cur[l];
            add_o[l] = gf_mul(mul_a[l], mul_b[l]) ^ add_b[l];

            wr_val[l] = cur[l];
            if (op_in == OP_GAUSS)        wr_val[l] = gf_mul(mul_a[l], mul_b[l]);
            else if (op_in == OP_LOAD_KEY) wr_val[l] = key_data[l*GF_BIT +: GF_BIT];
            else if (is_shift)             wr_val[l] = dataB_in[l*GF_BIT +: GF_BIT];
            else if (is_mac)               wr_val[l] = add_o[l];

            if (start_in)                  dout_n[l] = '0;
            else if (gauss_op_in == 2'b00) dout_n[l] = data_in[l*GF_BIT +: GF_BIT];
            else if (gauss_op_in == 2'b10) dout_n[l] = add_o[l];
            else                           dout_n[l] = cur[l];

            dbo_n[l] = is_shift ? cur[l] : dataB_in[l*GF_BIT +: GF_BIT];
        end
    end

    // Stalls clear valid_out but freeze every other register, bank and pointer included.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_out    <= 1'b0;
            start_out    <= 1'b0;
            op_out       <= '0;
            gauss_op_out <= '0;
            data_out     <= '0;
            dataA_out    <= '0;
            dataB_out    <= '0;
            r_out        <= '0;
            ptr          <= '0;
            for (int l = 0; l < LANES; l++)
                for (int d = 0; d < DEPTH; d++)
                    bank[l][d] <= '0;
        end else begin
            valid_out <= valid_in;
            if (valid_in) begin
                start_out    <= start_in;
                op_out       <= op_in;
                gauss_op_out <= gauss_op_in;
                dataA_out    <= dataA_in;
                if (op_in == OP_BANK_RST) ptr <= '0;
                else if (ptr_adv)         ptr <= ptr_next;
                for (int l = 0; l < LANES; l++) begin
                    if (wr_en) bank[l][ptr] <= wr_val[l];
                    r_out[l*GF_BIT +: GF_BIT]     <= wr_en ? wr_val[l] : cur[l];
                    data_out[l*GF_BIT +: GF_BIT]  <= dout_n[l];
                    dataB_out[l*GF_BIT +: GF_BIT] <= dbo_n[l];
                end
            end
        end
    end

    assign ptr_out = ptr;

endmodule

// File: tb/tb_processor_bc_lanes.sv
// Self-checking bench for processor_bc_lanes: directed scenarios plus random beats
// compared against a field-arithmetic reference model of the PE.
module tb_processor_bc_lanes;
    localparam int GB = 4, LN = 2, DP = 4, OL = 4, W = LN * GB;
    localparam int QGB = 8, QLN = 4, QDP = 2, QW = QLN * QGB;

    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;

    logic          valid_in, start_in, valid_out, start_out;
    logic [OL-1:0] op_in, op_out;
    logic [1:0]    gauss_op_in, gauss_op_out;
    logic [W-1:0]  key_data, data_in, data_out, dataA_in, dataA_out, dataB_in, dataB_out, r_out;
    logic [1:0]    ptr_out;

    logic          q_valid_in, q_start_in, q_valid_out, q_start_out;
    logic [OL-1:0] q_op_in, q_op_out;
    logic [1:0]    q_gauss_op_in, q_gauss_op_out;
    logic [QW-1:0] q_key_data, q_data_in, q_data_out, q_dataA_in, q_dataA_out;
    logic [QW-1:0] q_dataB_in, q_dataB_out, q_r_out;
    logic [0:0]    q_ptr_out;

    processor_bc_lanes #(.GF_BIT(GB), .LANES(LN), .DEPTH(DP), .OP_CODE_LEN(OL)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .valid_out(valid_out),
        .start_in(start_in), .start_out(start_out), .op_in(op_in), .op_out(op_out),
        .gauss_op_in(gauss_op_in), .gauss_op_out(gauss_op_out), .key_data(key_data),
        .data_in(data_in), .data_out(data_out), .dataA_in(dataA_in), .dataA_out(dataA_out),
        .dataB_in(dataB_in), .dataB_out(dataB_out), .r_out(r_out), .ptr_out(ptr_out));

    processor_bc_lanes #(.GF_BIT(QGB), .LANES(QLN), .DEPTH(QDP), .OP_CODE_LEN(OL)) dut8 (
        .clk(clk), .rst(rst), .valid_in(q_valid_in), .valid_out(q_valid_out),
        .start_in(q_start_in), .start_out(q_start_out), .op_in(q_op_in), .op_out(q_op_out),
        .gauss_op_in(q_gauss_op_in), .gauss_op_out(q_gauss_op_out), .key_data(q_key_data),
        .data_in(q_data_in), .data_out(q_data_out), .dataA_in(q_dataA_in),
        .dataA_out(q_dataA_out), .dataB_in(q_dataB_in), .dataB_out(q_dataB_out),
        .r_out(q_r_out), .ptr_out(q_ptr_out));

    int passed = 0, total = 0, failed = 0;

    int           m_bank [LN][DP];
    int           m_ptr;
    logic         e_valid, e_start;
    logic [OL-1:0] e_op;
    logic [1:0]   e_g, e_ptr;
    logic [W-1:0] e_data, e_dataA, e_dataB, e_r;
    logic [W-1:0] rec [6];

    // Schoolbook multiply with xtime reduction.
    function automatic int gmul(int a, int b, int nb, int poly);
        int r = 0;
        for (int i = 0; i < nb; i++) begin
            if (((b >> i) & 1) != 0) r = r ^ a;
            a = a << 1;
            if (((a >> nb) & 1) != 0) a = a ^ poly;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int l = 0; l < LN; l++)
            for (int d = 0; d < DP; d++) m_bank[l][d] = 0;
        m_ptr = 0; e_valid = 0; e_start = 0; e_op = '0; e_g = '0; e_ptr = '0;
        e_data = '0; e_dataA = '0; e_dataB = '0; e_r = '0;
    endtask

    task automatic model_step();
        int k, di, da, db, bk, ma, mb, ab, mo, ao, nv, opi;
        e_valid = valid_in;
        if (!valid_in) return;
        opi = int'(op_in);
        e_start = start_in; e_op = op_in; e_g = gauss_op_in; e_dataA = dataA_in;
        for (int l = 0; l < LN; l++) begin
            k  = int'((key_data >> (l * GB)) & 'hF);
            di = int'((data_in  >> (l * GB)) & 'hF);
            da = int'((dataA_in >> (l * GB)) & 'hF);
            db = int'((dataB_in >> (l * GB)) & 'hF);
            bk = m_bank[l][m_ptr];
            ma = (opi == 7) ? k : db;
            mb = (opi == 6 || opi == 7) ? da : (gauss_op_in[0] ? di : bk);
            ab = gauss_op_in[1] ? di : bk;
            mo = gmul(ma, mb, GB, 'h13);
            ao = mo ^ ab;
            nv = bk;
            case (opi)
                1:    if (start_in || gauss_op_in == 2'b01) nv = mo;
                3:    nv = k;
                4, 5: nv = db;
                6, 7: nv = ao;
                default: ;
            endcase
            e_data[l*GB +: GB]  = GB'(start_in ? 0 : (gauss_op_in == 2'b00) ? di :
                                      (gauss_op_in == 2'b10) ? ao : bk);
            e_dataB[l*GB +: GB] = GB'((opi == 4 || opi == 5) ? bk : db);
            e_r[l*GB +: GB]     = GB'(nv);
            m_bank[l][m_ptr] = nv;
        end
        if (opi == 2) m_ptr = 0;
        else if (opi >= 3 && opi <= 7) m_ptr = (m_ptr + 1) % DP;
        e_ptr = 2'(m_ptr);
    endtask

    task automatic check_all(input string ctx);
        check({ctx, ".valid_out"}, 64'(valid_out), 64'(e_valid));
        check({ctx, ".start_out"}, 64'(start_out), 64'(e_start));
        check({ctx, ".op_out"}, 64'(op_out), 64'(e_op));
        check({ctx, ".gauss_op_out"}, 64'(gauss_op_out), 64'(e_g));
        check({ctx, ".data_out"}, 64'(data_out), 64'(e_data));
        check({ctx, ".dataA_out"}, 64'(dataA_out), 64'(e_dataA));
        check({ctx, ".dataB_out"}, 64'(dataB_out), 64'(e_dataB));
        check({ctx, ".r_out"}, 64'(r_out), 64'(e_r));
        check({ctx, ".ptr_out"}, 64'(ptr_out), 64'(e_ptr));
    endtask

    task automatic beat(input string ctx, input logic v, input logic st, input logic [3:0] op,
                        input logic [1:0] g, input logic [W-1:0] k, input logic [W-1:0] di,
                        input logic [W-1:0] da, input logic [W-1:0] db);
        valid_in = v; start_in = st; op_in = op; gauss_op_in = g;
        key_data = k; data_in = di; dataA_in = da; dataB_in = db;
        @(posedge clk); #1;
        model_step();
        check_all(ctx);
    endtask

    task automatic do_reset(input string ctx);
        rst = 1'b1;
        #1;
        model_reset();
        check_all(ctx);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        valid_in = 0; start_in = 0; op_in = '0; gauss_op_in = '0;
        key_data = '0; data_in = '0; dataA_in = '0; dataB_in = '0;
        q_valid_in = 0; q_start_in = 0; q_op_in = '0; q_gauss_op_in = '0;
        q_key_data = '0; q_data_in = '0; q_dataA_in = '0; q_dataB_in = '0;
        model_reset();
        #2;
        check_all("reset");
        check("reset.dut8_r_out", 64'(q_r_out), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;

        // GF(2^8), four lanes: 0x57 * 0x83 = 0xC1, then start_in forces data_out to 0.
        q_valid_in = 1; q_op_in = 4'd7; q_key_data = {QLN{8'h57}}; q_dataA_in = {QLN{8'h83}};
        q_data_in = {QLN{8'hA5}};
        @(posedge clk); #1;
        check("gf8.r_out", 64'(q_r_out), 64'({QLN{8'hC1}}));
        check("gf8.ptr_out", 64'(q_ptr_out), 64'(1));
        check("gf8.data_pass", 64'(q_data_out), 64'({QLN{8'hA5}}));
        q_op_in = 4'd0; q_start_in = 1;
        @(posedge clk); #1;
        check("gf8.start_zero", 64'(q_data_out), 64'(0));
        check("gf8.start_out", 64'(q_start_out), 64'(1));
        q_valid_in = 0; q_start_in = 0;

        // Four interleaved MAC_A beats: 3*7 = 9 per entry, second pass cancels to 0.
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < DP; i++) begin
                beat("mac", 1, 0, 4'd6, 2'b00, '0, '0, 8'h77, 8'h33);
                check("mac.ptr", 64'(ptr_out), 64'((i + 1) % DP));
                check("mac.r_out", 64'(r_out), (p == 0) ? 64'h99 : 64'h00);
            end

        // Shift chain: first pass emits old zeros, second pass emits 5 then 6.
        beat("shift.rst", 1, 0, 4'd2, 2'b11, '0, '0, '0, 8'h00);
        beat("shift.w5", 1, 0, 4'd4, 2'b11, '0, '0, '0, 8'h55);
        check("shift.old0", 64'(dataB_out), 64'h00);
        beat("shift.w6", 1, 0, 4'd5, 2'b11, '0, '0, '0, 8'h66);
        check("shift.old1", 64'(dataB_out), 64'h00);
        beat("shift.rst2", 1, 0, 4'd2, 2'b11, '0, '0, '0, 8'h00);
        beat("shift.r5", 1, 0, 4'd4, 2'b11, '0, '0, '0, 8'h00);
        check("shift.out5", 64'(dataB_out), 64'h55);
        beat("shift.r6", 1, 0, 4'd4, 2'b11, '0, '0, '0, 8'h00);
        check("shift.out6", 64'(dataB_out), 64'h66);

        // Gauss eliminate: 7*3 ^ 4 = D, bank untouched.
        beat("gauss.rst", 1, 0, 4'd2, 2'b00, '0, '0, '0, '0);
        beat("gauss.load", 1, 0, 4'd3, 2'b00, 8'h33, '0, '0, '0);
        beat("gauss.rst2", 1, 0, 4'd2, 2'b00, '0, '0, '0, '0);
        beat("gauss.elim", 1, 0, 4'd1, 2'b10, '0, 8'h44, '0, 8'h77);
        check("gauss.data_out", 64'(data_out), 64'hDD);
        check("gauss.bank_kept", 64'(r_out), 64'h33);
        check("gauss.ptr_kept", 64'(ptr_out), 64'(0));

        // MAC_KEY run unstalled, then replayed with a 3-cycle stall in the middle.
        for (int pass = 0; pass < 2; pass++) begin
            logic [W-1:0] kk, aa;
            do_reset("stall.reset");
            for (int i = 0; i < 6; i++) begin
                kk = W'(8'h1F + 8'(i * 37)); aa = W'(8'hC2 ^ 8'(i * 19));
                beat("stall.mac", 1, 0, 4'd7, 2'b00, kk, 8'h5A, aa, 8'hE1);
                if (pass == 0) rec[i] = r_out;
                else check("stall.same_result", 64'(r_out), 64'(rec[i]));
                if (pass == 1 && i == 2)
                    for (int s = 0; s < 3; s++) begin
                        beat("stall.hold", 0, 1, 4'd3, 2'b10, W'($urandom), W'($urandom),
                             W'($urandom), W'($urandom));
                        check("stall.valid_out", 64'(valid_out), 64'(0));
                        check("stall.ptr", 64'(ptr_out), 64'(3));
                    end
            end
        end

        // Mid-stream reset with a populated bank, then a fresh MAC_A: 2*9 = 1.
        rst = 1'b1;
        #1;
        check("rst.r_out_now", 64'(r_out), 64'(0));
        check("rst.data_out_now", 64'(data_out), 64'(0));
        check("rst.ptr_now", 64'(ptr_out), 64'(0));
        do_reset("rst.mid");
        beat("rst.mac", 1, 0, 4'd6, 2'b00, '0, '0, 8'h99, 8'h22);
        check("rst.mac_r_out", 64'(r_out), 64'h11);

        // BANK_RST with start_in: pointer clears and data_out forced to 0.
        beat("brst.adv", 1, 0, 4'd3, 2'b00, 8'h21, '0, '0, '0);
        beat("brst.start", 1, 1, 4'd2, 2'b00, '0, 8'hFF, '0, '0);
        check("brst.ptr", 64'(ptr_out), 64'(0));
        check("brst.data_out", 64'(data_out), 64'(0));

        for (int i = 0; i < 400; i++)
            beat("rand", ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
                 4'($urandom_range(0, 15)), 2'($urandom), W'($urandom), W'($urandom),
                 W'($urandom), W'($urandom));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/processor_bc_lanes.md
# processor_bc_lanes

Multi-lane, pipelined successor processing element for the GF(2^GF_BIT) systolic array used in UOV key/sign computation (key-matrix MAC, B/C column shifting, Gaussian elimination). It handles LANES field elements per beat and holds a bank of DEPTH accumulator entries per lane, so DEPTH independent matrices can be interleaved through one array. Control and data pass-through are registered, giving a uniform one-cycle hop between neighbouring PEs. A valid qualifier allows stalls.

## Interface
- GF_BIT, 4, field width; 4 uses poly x^4+x+1, 8 uses x^8+x^4+x^3+x+1.
- LANES, 2, parallel GF elements per beat (≥1).
- DEPTH, 4, accumulator entries per lane (≥1).
- OP_CODE_LEN, 4, opcode width.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- valid_in / valid_out  in/out  1  beat qualifier / registered copy.
- start_in / start_out  in/out  1  row-start marker / registered copy.
- op_in / op_out  in/out  OP_CODE_LEN  opcode / registered copy.
- gauss_op_in / gauss_op_out  in/out  2  Gauss sub-op / registered copy.
- key_data  in  LANES*GF_BIT  key coefficients, lane i at bits [i*GF_BIT +: GF_BIT].
- data_in / data_out  in/out  LANES*GF_BIT  elimination data path.
- dataA_in / dataA_out  in/out  LANES*GF_BIT  A operand / registered copy.
- dataB_in / dataB_out  in/out  LANES*GF_BIT  B operand / shift chain.
- r_out  out  LANES*GF_BIT  registered bank[ptr] after each update.
- ptr_out  out  max(1,$clog2(DEPTH))  current bank pointer.

## Operation
- Per lane: mul_a = (op==7) ? key : dataB; mul_b = (op==6||op==7) ? dataA : (gauss_op[0] ? data_in : bank[ptr]); add_b = gauss_op[1] ? data_in : bank[ptr]; add_o = mul_o ^ add_b.
- Multiply is full GF(2^GF_BIT) product reduced by the parameter polynomial; add is XOR. Lanes are independent.
- Opcodes (effective only on valid_in=1):
  - 0 NOP: bank unchanged.
  - 1 GAUSS: bank[ptr] <= mul_o if start_in or gauss_op==01, else unchanged.
  - 2 BANK_RST: ptr <= 0; bank unchanged.
  - 3 LOAD_KEY: bank[ptr] <= key_data.
  - 4/5 SHIFT_B: bank[ptr] <= dataB_in; dataB_out <= old bank[ptr].
  - 6 MAC_A / 7 MAC_KEY: bank[ptr] <= add_o.
  - 8–15: treated as NOP.
- Pointer: after a valid beat with op in {3,4,5,6,7}, ptr <= (ptr==DEPTH-1) ? 0 : ptr+1. With DEPTH=1, ptr stays 0.
- data_out next value:
  - start_in=1: 0.
  - gauss_op 00: data_in (pass).
  - gauss_op 10: add_o.
  - otherwise: old bank[ptr].
- dataB_out next value: old bank[ptr] for op 4/5, else dataB_in.
- dataA_out, op_out, gauss_op_out, start_out are the registered inputs.

## Timing
- Reset, asynchronous: every bank entry 0, ptr 0, all outputs 0 (including valid_out).
- Latency 1 cycle for all outputs. bank/ptr written at the edge that consumes the beat. r_out shows the written entry (pre-increment ptr) one cycle later.
- valid_in=0 (stall):
  - Bank and ptr hold.
  - valid_out <= 0.
  - All other output registers hold their previous values.
- Reads use pre-edge bank[ptr]; read-modify-write of the same entry in one beat is the intended behaviour.
- Back-to-back MACs to the same matrix require DEPTH beats of spacing (one per interleaved matrix). The sequencer guarantees this; the PE does not check.
- Reset asserted mid-row discards all partial accumulations. The first beat after deassertion sees bank=0, ptr=0.
- BANK_RST together with start_in: ptr reset takes effect and data_out=0.

## Test plan
- Reset: assert rst mid-stream with bank nonzero -> all outputs 0 and ptr_out 0 immediately; after release, a MAC_A with dataB=2, dataA=9 gives r_out lane=1.
- MAC interleave, GF_BIT=4, DEPTH=4: 4 MAC_A beats dataB=3, dataA=7 -> ptr_out 1,2,3,0, each entry 9; repeat -> each entry 0.
- SHIFT_B chain: load entries 5,6 via op 4 -> dataB_out shows old entries 0,0; second pass shows 5,6 one cycle after each beat.
- Gauss eliminate: bank[ptr]=3, data_in=4, dataB=7, gauss_op=10, op=1 -> data_out=4^9=D next cycle; bank unchanged.
- Stall: valid_in low 3 cycles during MAC_KEY sequence -> ptr, bank and data outputs frozen, valid_out 0; result identical to the unstalled run.
- GF_BIT=8, LANES=4: MAC_KEY key=0x57, dataA=0x83 -> lane result 0xC1 on every lane; start_in=1 forces data_out=0.
